// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction memory writer. Receives a byte stream over a
//   valid/ready handshake: LEN_HI, LEN_LO, N big-endian 16-bit words, CHK.
//   Each word is written to consecutive addresses starting at 0.
//   CHK must equal the XOR of every byte before it.
//   The CPU is held in reset until a load completes with a good checksum.
//
// Ports
//   clk_pi         system clock, rising edge
//   reset_n_pi     asynchronous active-low reset
//   start_pi       one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   byte_valid_pi  source presents a byte
//   byte_data_pi   byte value
//   byte_ready_po  loader accepts a byte (transfer when valid & ready)
//   wr_en_po       instruction memory write strobe, one cycle per word
//   wr_addr_po     word address of the write
//   wr_data_po     instruction word of the write
//   cpu_reset_po   active-high reset to the processor
//   done_po        load completed with a good checksum
//   error_po       load failed (oversize length or bad checksum)
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_pi,
  input  logic                  reset_n_pi,
  input  logic                  start_pi,
  input  logic                  byte_valid_pi,
  input  logic [7:0]            byte_data_pi,
  output logic                  byte_ready_po,
  output logic                  wr_en_po,
  output logic [ADDR_WIDTH-1:0] wr_addr_po,
  output logic [15:0]           wr_data_po,
  output logic                  cpu_reset_po,
  output logic                  done_po,
  output logic                  error_po
);

  localparam int          DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  state_t              state;
  logic [7:0]          len_hi;
  logic [15:0]         len;
  logic [7:0]          data_hi;
  logic [7:0]          run_xor;
  // One bit wider than the address so that N = DEPTH can be counted.
  logic [ADDR_WIDTH:0] idx;

  logic        accept;
  logic [16:0] len_next;
  logic        last_word;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_ready_po = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: byte_ready_po = 1'b1;
      default:                                 byte_ready_po = 1'b0;
    endcase
  end

  assign accept    = byte_valid_pi && byte_ready_po;
  // Length as it will be once the LEN_LO byte is latched.
  assign len_next  = {1'b0, len_hi, byte_data_pi};
  // N >= 1 whenever DATA_LO is reached, so len - 1 never wraps here.
  assign last_word = (16'(idx) == len - 16'd1);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state        <= IDLE;
      len_hi       <= '0;
      len          <= '0;
      data_hi      <= '0;
      run_xor      <= '0;
      idx          <= '0;
      wr_en_po     <= 1'b0;
      wr_addr_po   <= '0;
      wr_data_po   <= '0;
      cpu_reset_po <= 1'b1;
      done_po      <= 1'b0;
      error_po     <= 1'b0;
    end else begin
      wr_en_po <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_pi) begin
            state        <= LEN_HI;
            idx          <= '0;
            run_xor      <= '0;
            done_po      <= 1'b0;
            error_po     <= 1'b0;
            cpu_reset_po <= 1'b1;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi  <= byte_data_pi;
            run_xor <= run_xor ^ byte_data_pi;
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len     <= len_next[15:0];
            run_xor <= run_xor ^ byte_data_pi;
            if (len_next > DEPTH_W) begin
              state    <= ERROR;
              error_po <= 1'b1;
            end else if (len_next == 17'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            data_hi <= byte_data_pi;
            run_xor <= run_xor ^ byte_data_pi;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            wr_en_po   <= 1'b1;
            wr_addr_po <= idx[ADDR_WIDTH-1:0];
            wr_data_po <= {data_hi, byte_data_pi};
            idx        <= idx + 1'b1;
            run_xor    <= run_xor ^ byte_data_pi;
            state      <= last_word ? CHECK : DATA_HI;
          end
        end
        CHECK: begin
          // The checksum byte is compared, never folded into run_xor.
          if (accept) begin
            if (byte_data_pi == run_xor) begin
              state        <= DONE;
              done_po      <= 1'b1;
              cpu_reset_po <= 1'b0;
            end else begin
              state    <= ERROR;
              error_po <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Scoreboarded bench for imem_loader. Each load's stream is run through a
//   reference model that pushes the expected memory writes into a queue;
//   an independent monitor pops and compares on every write strobe.
//   Status outputs are compared one cycle after the final byte.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk_pi = 1'b0;
  logic          reset_n_pi = 1'b0;
  logic          start_pi = 1'b0;
  logic          byte_valid_pi = 1'b0;
  logic [7:0]    byte_data_pi = '0;
  logic          byte_ready_po;
  logic          wr_en_po;
  logic [AW-1:0] wr_addr_po;
  logic [15:0]   wr_data_po;
  logic          cpu_reset_po;
  logic          done_po;
  logic          error_po;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_pi        (clk_pi),
    .reset_n_pi    (reset_n_pi),
    .start_pi      (start_pi),
    .byte_valid_pi (byte_valid_pi),
    .byte_data_pi  (byte_data_pi),
    .byte_ready_po (byte_ready_po),
    .wr_en_po      (wr_en_po),
    .wr_addr_po    (wr_addr_po),
    .wr_data_po    (wr_data_po),
    .cpu_reset_po  (cpu_reset_po),
    .done_po       (done_po),
    .error_po      (error_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk_pi) begin
    wr_t e;
    if (reset_n_pi === 1'b1 && wr_en_po !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want no write at %0t",
                 wr_addr_po, wr_data_po, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_en", 32'(wr_en_po), 32'd1);
        check("wr_addr", 32'(wr_addr_po), 32'(e.addr));
        check("wr_data", 32'(wr_data_po), 32'(e.data));
      end
    end
  end

  // Reference model: interpret the stream format directly.
  task automatic model(input bq_t s, output logic exp_done);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = int'({s[0], s[1]});
    if (n > DEPTH) begin
      exp_done = 1'b0;
      return;
    end
    x = '0;
    for (int i = 0; i < 2 * n + 2; i++) x ^= s[i];
    for (int i = 0; i < n; i++) begin
      w.addr = AW'(i);
      w.data = {s[2 + 2 * i], s[3 + 2 * i]};
      exp_q.push_back(w);
    end
    exp_done = (s[2 * n + 2] == x);
  endtask

  function automatic bq_t make_stream(input int n, input bit bad_chk);
    bq_t         q;
    logic [15:0] n16;
    logic [7:0]  b;
    logic [7:0]  x;
    n16 = 16'(n);
    q.push_back(n16[15:8]);
    q.push_back(n16[7:0]);
    if (n > DEPTH) return q;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      q.push_back(b);
    end
    x = '0;
    foreach (q[i]) x ^= q[i];
    if (bad_chk) x ^= 8'($urandom_range(1, 255));
    q.push_back(x);
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    byte_valid_pi = 1'b1;
    byte_data_pi  = b;
    while (byte_ready_po !== 1'b1 && budget < 100) begin
      @(posedge clk_pi); #1;
      budget++;
    end
    if (budget >= 100) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready low for 100 cycles want ready high at %0t", $time);
      byte_valid_pi = 1'b0;
      return;
    end
    @(posedge clk_pi); #1;
    byte_valid_pi = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      start_pi = glitch && (i == 0);
      @(posedge clk_pi); #1;
    end
    start_pi = 1'b0;
  endtask

  task automatic do_start();
    start_pi = 1'b1;
    @(posedge clk_pi); #1;
    start_pi = 1'b0;
    check("start_ready", 32'(byte_ready_po), 32'd1);
    check("start_cpu_reset", 32'(cpu_reset_po), 32'd1);
    check("start_done_clr", 32'(done_po), 32'd0);
    check("start_error_clr", 32'(error_po), 32'd0);
  endtask

  // Full load: model, start, send every byte, then check final status.
  task automatic run_load(input bq_t s, input int gap_lo, input int gap_hi, input bit glitch);
    logic exp_done;
    model(s, exp_done);
    do_start();
    foreach (s[i]) begin
      send_byte(s[i]);
      if (i != s.size() - 1) idle_cycles($urandom_range(gap_lo, gap_hi), glitch);
    end
    check("done", 32'(done_po), 32'(exp_done));
    check("error", 32'(error_po), 32'(!exp_done));
    check("ready_after", 32'(byte_ready_po), 32'd0);
    check("cpu_reset", 32'(cpu_reset_po), 32'(!exp_done));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle_cycles(2, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_po), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en_po), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_po), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data_po), 32'd0);
    check({tag, "_done"}, 32'(done_po), 32'd0);
    check({tag, "_error"}, 32'(error_po), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset_po), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish by 2000000 at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t nominal;
    bq_t s;
    int  r;
    int  n;
    nominal = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};

    #12;
    check_reset_values("reset");
    @(posedge clk_pi); #1;
    reset_n_pi = 1'b1;
    idle_cycles(2, 1'b0);

    // Nominal, bad checksum, zero length, oversize.
    run_load(nominal, 0, 0, 1'b0);
    s = nominal; s[6] = 8'h43;
    run_load(s, 0, 0, 1'b0);
    s = '{8'h00, 8'h00, 8'h00};
    run_load(s, 0, 0, 1'b0);
    s = '{8'h01, 8'h01};
    run_load(s, 0, 0, 1'b0);

    // Gapped stream with ignored start pulses, then restart from DONE.
    run_load(nominal, 3, 3, 1'b1);
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    run_load(s, 0, 0, 1'b0);

    // Reset mid-load after byte 12, then a clean reload.
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    #2;
    reset_n_pi = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk_pi); #1;
    reset_n_pi = 1'b1;
    idle_cycles(2, 1'b0);
    run_load(nominal, 0, 0, 1'b0);

    // Largest legal image: last write lands on DEPTH-1.
    s = make_stream(DEPTH, 1'b0);
    run_load(s, 0, 0, 1'b0);

    // Randomized loads.
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       n = $urandom_range(1, 8);
      else if (r == 6) n = 0;
      else if (r == 7) n = DEPTH;
      else if (r == 8) n = $urandom_range(DEPTH + 1, 65535);
      else             n = $urandom_range(1, 20);
      s = make_stream(n, $urandom_range(0, 3) == 0);
      run_load(s, 0, 2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
